// File: rtl/apb_completer_regfile.sv
// APB completer with NumRegs byte-strobed registers and a fixed wait-state count.
// Define APB_COMPLETER_PSLVERR_EN to flag out-of-range transfers on PSLVERR.
module apb_completer_regfile #(
   parameter int                   AddrWidth  = 32,
   parameter int                   DataWidth  = 32,
   parameter int                   NumRegs    = 16,
   parameter int                   WaitStates = 2,
   parameter logic [AddrWidth-1:0] BaseAddr   = '0,
   parameter int                   StrbWidth  = DataWidth / 8
) (
   input  logic                           PCLK,
   input  logic                           reset,
   input  logic                           PSEL,
   input  logic                           PENABLE,
   input  logic                           PWRITE,
   input  logic [AddrWidth-1:0]           PADDR,
   input  logic [DataWidth-1:0]           PWDATA,
   input  logic [StrbWidth-1:0]           PSTRB,
   output logic                           PREADY,
   output logic [DataWidth-1:0]           PRDATA,
   output logic                           PSLVERR,
   output logic [NumRegs*DataWidth-1:0]   RegOut
);

   localparam int         IdxW    = (NumRegs > 1) ? $clog2(NumRegs) : 1;
   localparam int         ShiftW  = $clog2(StrbWidth);
   localparam logic [7:0] WaitCnt = 8'(WaitStates);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0]           state_reg, state_next;
   logic [7:0]           cnt_reg, cnt_next;
   logic                 write_reg, write_next;
   logic                 oor_reg, oor_next;
   logic [IdxW-1:0]      idx_reg, idx_next;
   logic                 pready_reg, pready_next;
   logic [DataWidth-1:0] prdata_reg, prdata_next;
   logic                 resp;
   logic                 commit;

   logic [AddrWidth-1:0] offset;
   logic [IdxW-1:0]      addr_idx;
   logic                 addr_oor;

   logic [DataWidth-1:0] reg_array [NumRegs];

   assign offset   = PADDR - BaseAddr;
   assign addr_idx = IdxW'(offset >> ShiftW);
   assign addr_oor = (PADDR < BaseAddr) || ((offset >> ShiftW) >= AddrWidth'(NumRegs));

   // resp marks the edge that opens the single PREADY cycle; the transfer
   // attributes used for the response are the ones valid after that edge.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      write_next  = write_reg;
      oor_next    = oor_reg;
      idx_next    = idx_reg;
      resp        = 1'b0;
      pready_next = 1'b0;
      prdata_next = '0;
      case (state_reg)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_next = ACCESS;
               write_next = PWRITE;
               idx_next   = addr_idx;
               oor_next   = addr_oor;
               cnt_next   = WaitCnt;
               resp       = (WaitStates == 0);
            end
         end
         ACCESS: begin
            if (pready_reg || !PSEL || !PENABLE) begin
               state_next = IDLE;
            end else begin
               resp     = (cnt_reg <= 8'd1);
               cnt_next = (cnt_reg == 8'd0) ? 8'd0 : cnt_reg - 8'd1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (resp) begin
         pready_next = 1'b1;
         if (!write_next && !oor_next) begin
            prdata_next = reg_array[idx_next];
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         write_reg  <= 1'b0;
         oor_reg    <= 1'b0;
         idx_reg    <= '0;
         pready_reg <= 1'b0;
         prdata_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         write_reg  <= write_next;
         oor_reg    <= oor_next;
         idx_reg    <= idx_next;
         pready_reg <= pready_next;
         prdata_reg <= prdata_next;
      end
   end

   assign PREADY = pready_reg;
   assign PRDATA = prdata_reg;

`ifdef APB_COMPLETER_PSLVERR_EN
   logic pslverr_reg;
   always_ff @(posedge PCLK) begin
      if (!reset) begin
         pslverr_reg <= 1'b0;
      end else begin
         pslverr_reg <= resp && oor_next;
      end
   end
   assign PSLVERR = pslverr_reg;
`else
   assign PSLVERR = 1'b0;
`endif

   // Writes land on the edge that closes the PREADY cycle.
   assign commit = (state_reg == ACCESS) && pready_reg && write_reg && !oor_reg;

   generate
      for (genvar gi = 0; gi < NumRegs; gi++) begin : g_reg
         logic [DataWidth-1:0] q_reg;
         always_ff @(posedge PCLK) begin
            if (!reset) begin
               q_reg <= '0;
            end else if (commit && (idx_reg == IdxW'(gi))) begin
               for (int b = 0; b < StrbWidth; b++) begin
                  if (PSTRB[b]) begin
                     q_reg[b*8 +: 8] <= PWDATA[b*8 +: 8];
                  end
               end
            end
         end
         assign reg_array[gi]                    = q_reg;
         assign RegOut[gi*DataWidth +: DataWidth] = q_reg;
      end
   endgenerate

endmodule

// File: tb/tb_apb_completer_regfile.sv
// Scoreboard bench for apb_completer_regfile: directed scenarios then random traffic.
module tb_apb_completer_regfile;

   localparam int WS = 2;
   localparam int NR = 16;

   logic          PCLK = 1'b0;
   logic          reset = 1'b0;
   logic          PSEL = 1'b0;
   logic          PENABLE = 1'b0;
   logic          PWRITE = 1'b0;
   logic [31:0]   PADDR = '0;
   logic [31:0]   PWDATA = '0;
   logic [3:0]    PSTRB = '0;
   logic          PREADY;
   logic [31:0]   PRDATA;
   logic          PSLVERR;
   logic [NR*32-1:0] RegOut;

   apb_completer_regfile #(
      .AddrWidth(32), .DataWidth(32), .NumRegs(NR), .WaitStates(WS), .BaseAddr(32'h0)
   ) dut (
      .PCLK(PCLK), .reset(reset), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY),
      .PRDATA(PRDATA), .PSLVERR(PSLVERR), .RegOut(RegOut)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      int          cyc;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;
   logic [31:0] mdl [NR];

   always @(posedge PCLK) cyc <= cyc + 1;

   // Monitor: every PREADY pops one expectation; idle cycles must show zeros.
   always @(negedge PCLK) begin
      if (mon_en) begin
         if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL missing_pready: expected at cycle %0d, now %0d", sbq[0].cyc, cyc);
            void'(sbq.pop_front());
         end
         if (PREADY === 1'b1) begin
            n_cmp++;
            if (sbq.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_pready: cycle %0d PRDATA=%h", cyc, PRDATA);
            end else begin
               mon_e = sbq.pop_front();
               if (mon_e.cyc != cyc || PRDATA !== mon_e.rd || PSLVERR !== mon_e.err) begin
                  n_bad++;
                  $display("FAIL response: got cyc=%0d rd=%h err=%b, want cyc=%0d rd=%h err=%b",
                           cyc, PRDATA, PSLVERR, mon_e.cyc, mon_e.rd, mon_e.err);
               end else begin
                  $display("resp cyc=%0d rd=%h err=%b ok", cyc, PRDATA, PSLVERR);
               end
            end
         end else begin
            n_cmp++;
            if (PREADY !== 1'b0 || PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
               n_bad++;
               $display("FAIL idle_outputs: cycle %0d PREADY=%b PRDATA=%h PSLVERR=%b, want 0/0/0",
                        cyc, PREADY, PRDATA, PSLVERR);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge PCLK);
      #1;
   endtask

   task automatic check_regs(input string tag);
      logic [NR*32-1:0] exp_flat;
      for (int k = 0; k < NR; k++) exp_flat[k*32 +: 32] = mdl[k];
      n_cmp++;
      if (RegOut !== exp_flat) begin
         n_bad++;
         $display("FAIL regout_%s: got %h want %h", tag, RegOut, exp_flat);
      end
   endtask

   // One APB transfer starting at the current cycle (T0). abort_k/rst_k in 1..WS
   // drop the select or pulse reset during T_k; 0 disables that disturbance.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int abort_k, input int rst_k);
      bit          oor;
      int          idx;
      bit          done;
      exp_t        e;
      oor  = (addr >= 32'(NR * 4));
      idx  = int'(addr >> 2);
      done = 1'b1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
      if (abort_k == 0 && rst_k == 0) begin
         e.cyc = cyc + 1 + WS;
         e.rd  = (!wr && !oor) ? mdl[idx] : 32'h0;
`ifdef APB_COMPLETER_PSLVERR_EN
         e.err = oor;
`else
         e.err = 1'b0;
`endif
         sbq.push_back(e);
      end
      next_cycle();
      PENABLE = 1'b1;
      for (int t = 1; t <= WS + 1; t++) begin
         if (t == abort_k) begin
            if ($urandom_range(1) == 1) PSEL = 1'b0;
            PENABLE = 1'b0;
            next_cycle();
            done = 1'b0;
            break;
         end
         if (t == rst_k) begin
            reset = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
            next_cycle();
            reset = 1'b1;
            for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
            done = 1'b0;
            break;
         end
         next_cycle();
      end
      if (done && wr && !oor) begin
         for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
      end
      PSEL = 1'b0; PENABLE = 1'b0;
      $display("xfer %s addr=%h data=%h strb=%b abort=%0d rst=%0d", wr ? "W" : "R",
               addr, data, strb, abort_k, rst_k);
      check_regs(wr ? "wr" : "rd");
   endtask

   initial begin
      int  ak, rk, sel;
      bit  wr;
      logic [31:0] a;
      for (int k = 0; k < NR; k++) mdl[k] = 32'h0;
      reset = 1'b0;
      next_cycle();
      next_cycle();
      @(negedge PCLK);
      n_cmp++;
      if (PREADY !== 1'b0 || PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: PREADY=%b PRDATA=%h PSLVERR=%b, want 0/0/0", PREADY, PRDATA, PSLVERR);
      end
      check_regs("reset");
      reset = 1'b1;
      next_cycle();
      mon_en = 1'b1;

      xfer(1'b1, 32'h8,  32'hDEADBEEF, 4'hF,    0, 0);
      xfer(1'b1, 32'h8,  32'h11223344, 4'b0101, 0, 0);
      xfer(1'b0, 32'h8,  32'h0,        4'h0,    0, 0);
      xfer(1'b1, 32'h40, 32'h12345678, 4'hF,    0, 0);
      xfer(1'b0, 32'h40, 32'h0,        4'hF,    0, 0);
      xfer(1'b1, 32'hC,  32'hCAFEF00D, 4'hF,    1, 0);
      xfer(1'b0, 32'h8,  32'h0,        4'h0,    0, 0);
      xfer(1'b1, 32'h10, 32'h55AA55AA, 4'h0,    0, 0);
      next_cycle();
      xfer(1'b1, 32'h4,  32'hA5A5A5A5, 4'hF,    0, 2);
      xfer(1'b1, 32'h4,  32'hA5A5A5A5, 4'hF,    0, 0);
      xfer(1'b0, 32'h4,  32'h0,        4'h0,    0, 0);

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(9);
         if (sel < 7)       a = 32'($urandom_range(NR - 1) * 4 + $urandom_range(3));
         else if (sel < 9)  a = 32'($urandom_range(255, NR * 4));
         else               a = $urandom() | 32'h8000_0000;
         wr = ($urandom_range(1) == 1);
         ak = ($urandom_range(9) == 0) ? $urandom_range(WS, 1) : 0;
         rk = (ak == 0 && $urandom_range(24) == 0) ? $urandom_range(WS, 1) : 0;
         xfer(wr, a, $urandom(), 4'($urandom_range(15)), ak, rk);
         if ($urandom_range(2) == 0) next_cycle();
      end

      for (int i = 0; i < 4; i++) next_cycle();
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sbq.size());
      end
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
